mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage directly upstream of the writeback stage.
- Accepts one instruction per handshake from the execute stage and runs the data-memory request/response handshake for loads and stores.
- Aligns and extends load data (lb/lbu/lh/lhu/lw) and registers everything the writeback stage and RVFI need.
- Writeback consumes mem_wb_valid plus an already-aligned mem_data_out; it performs no byte/halfword extraction itself.

Parameters:
- RESET_PC, 32'h40000000, value driven on wb_pc_rdata while idle or after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  execute stage presents a valid instruction
- ex_rdy  out  1  stage can accept this cycle
- flush  in  1  discard the instruction held or in flight in this stage
- alu_out  in  32  effective address, or ALU result for non-memory ops
- rs2_data  in  32  store source data
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- funct3  in  3  load/store width: 000 b, 001 h, 010 w, 100 bu, 101 hu
- cw_in  in  control_word  control word; passed through unmodified
- dmem_address  out  32  word-aligned data-memory address
- dmem_read  out  1  data-memory read request
- dmem_write  out  1  data-memory write request
- dmem_wmask  out  4  byte-enable mask for stores
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  read data from memory
- dmem_resp  in  1  memory completes the current request
- mem_wb_valid  out  1  writeback registers hold a valid instruction
- mem_data_out  out  32  aligned and extended load data; 0 for non-loads
- wb_alu_out  out  32  registered alu_out
- wb_cw  out  control_word  registered cw_in
- wb_mem_addr  out  32  registered dmem_address, for RVFI
- wb_rmask  out  4  read byte mask, for RVFI
- wb_wmask  out  4  write byte mask, for RVFI
- wb_mem_rdata  out  32  raw dmem_rdata, for RVFI
- wb_mem_wdata  out  32  dmem_wdata as sent, for RVFI
- wb_pc_rdata  out  32  cw_in.rvfi.pc_rdata, registered

Behaviour:
- State machine: IDLE, WAIT, DRAIN.
- ex_rdy = (state==IDLE) && !rst.
- Acceptance is ex_valid && ex_rdy && !flush.
- Reset:
  - state goes to IDLE.
  - mem_wb_valid, dmem_read, dmem_write, dmem_wmask, all wb_* data outputs and mem_data_out go to 0.
  - wb_pc_rdata goes to RESET_PC.
  - Reset during WAIT or DRAIN drops the request in the same cycle; the memory model tolerates an abandoned request.
- IDLE, accepting a non-memory op: output registers load on that edge; mem_wb_valid=1 next cycle (latency 1); mem_data_out=0; rmask=wmask=0.
- IDLE, accepting a memory op:
  - On that edge, latch alu_out, rs2_data, funct3, mem_read/mem_write and cw_in into internal registers, then go to WAIT.
  - mem_wb_valid=0 on the next cycle.
- IDLE, nothing accepted: mem_wb_valid=0 next cycle.
- WAIT:
  - dmem_read or dmem_write is held high.
  - Address, mask and data stay constant, driven from the latched registers.
  - On dmem_resp: output registers load, mem_wb_valid=1 next cycle, state goes to IDLE.
  - A memory op therefore takes request cycles + 1 cycle to reach writeback.
- Request fields:
  - dmem_address = {addr[31:2],2'b00}; off = addr[1:0].
  - sb: wmask 4'b0001<<off; wdata = rs2[7:0]<<(8*off).
  - sh: wmask 4'b0011<<(2*off[1]); wdata = rs2[15:0]<<(16*off[1]).
  - sw: wmask 4'b1111; wdata = rs2.
  - Loads: dmem_wmask=0; rmask uses the same pattern as wmask.
  - off[0] on halfword and off[1:0] on word accesses are ignored (forced aligned). The decoder never issues misaligned accesses.
- Load data:
  - lb: sign-extend dmem_rdata byte[off]; lbu: zero-extend byte[off].
  - lh: sign-extend half[off[1]]; lhu: zero-extend half[off[1]].
  - lw: dmem_rdata.
  - Stores: mem_data_out=0.
- Flush:
  - In IDLE: flush blocks acceptance, and mem_wb_valid=0 next cycle.
  - In WAIT: go to DRAIN. The request stays asserted until dmem_resp because memory requests cannot be withdrawn; a flushed store still writes memory. On dmem_resp, go to IDLE with mem_wb_valid=0.
  - In DRAIN: flush has no further effect.
- Simultaneous dmem_resp and flush in WAIT: the instruction is discarded (mem_wb_valid=0) and state goes to IDLE; there is no DRAIN cycle.
- dmem_resp outside WAIT/DRAIN is ignored.
- mem_wb_valid is high for exactly one cycle per completed instruction.

Test Plan:
- Reset then idle 3 cycles -> mem_wb_valid=0, dmem_read=dmem_write=0, wb_pc_rdata=0x40000000, ex_rdy=1.
- Non-memory op with alu_out=0x1234 -> next cycle mem_wb_valid=1, wb_alu_out=0x1234, mem_data_out=0, no dmem request.
- lb at 0x80000003, memory returns 0x80FF7F01 after 2-cycle delay:
  - dmem_address=0x80000000, dmem_read held for 2 cycles.
  - Next cycle mem_data_out=0xFFFFFF80, rmask=4'b1000, ex_rdy=0 throughout WAIT.
- lhu at off=2 with rdata=0xBEEF0000 -> mem_data_out=0x0000BEEF, rmask=4'b1100. lh at off=2 with the same rdata -> mem_data_out=0xFFFFBEEF.
- sb at 0x100 with off=1 and rs2=0xAB -> dmem_write=1, dmem_wmask=4'b0010, dmem_wdata=0x0000AB00; after resp, mem_wb_valid=1 with wb_wmask=4'b0010 and mem_data_out=0.
- Flush and reset cases:
  - sw in WAIT, flush pulsed, resp 3 cycles later -> dmem_write held until resp, mem_wb_valid stays 0, ex_rdy returns to 1 the cycle after resp.
  - Repeat with resp coincident with flush -> IDLE next cycle, no valid output.
  - rst asserted during WAIT -> dmem_read=0 next cycle.

Source files
------------

// File: rtl/mem_stage_if.sv
// Control-word types and the bundled execute/memory/writeback port
// of the memory-access pipeline stage.
package mem_stage_pkg;
    typedef struct packed {
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] insn;
    } rvfi_t;

    typedef struct packed {
        rvfi_t       rvfi;
        logic        reg_write;
        logic [4:0]  rd;
    } control_word;
endpackage

interface mem_stage_if;
    import mem_stage_pkg::*;

    logic        ex_valid;
    logic        ex_rdy;
    logic        flush;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    control_word cw_in;

    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    logic        mem_wb_valid;
    logic [31:0] mem_data_out;
    logic [31:0] wb_alu_out;
    control_word wb_cw;
    logic [31:0] wb_mem_addr;
    logic [3:0]  wb_rmask;
    logic [3:0]  wb_wmask;
    logic [31:0] wb_mem_rdata;
    logic [31:0] wb_mem_wdata;
    logic [31:0] wb_pc_rdata;

    // The stage itself: consumes execute/memory inputs, drives requests and writeback.
    modport master (
        input  ex_valid, flush, alu_out, rs2_data, mem_read, mem_write, funct3, cw_in,
        input  dmem_rdata, dmem_resp,
        output ex_rdy, dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        output mem_wb_valid, mem_data_out, wb_alu_out, wb_cw, wb_mem_addr,
        output wb_rmask, wb_wmask, wb_mem_rdata, wb_mem_wdata, wb_pc_rdata
    );

    // The surrounding pipeline and data memory.
    modport slave (
        output ex_valid, flush, alu_out, rs2_data, mem_read, mem_write, funct3, cw_in,
        output dmem_rdata, dmem_resp,
        input  ex_rdy, dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        input  mem_wb_valid, mem_data_out, wb_alu_out, wb_cw, wb_mem_addr,
        input  wb_rmask, wb_wmask, wb_mem_rdata, wb_mem_wdata, wb_pc_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: runs the data-memory handshake for loads/stores,
// aligns load data and registers everything writeback and RVFI consume.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h40000000
) (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.master bus
);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rs2_q, rs2_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    control_word cw_q, cw_d;

    logic        valid_q, valid_d;
    logic [31:0] data_out_q, data_out_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    control_word wb_cw_q, wb_cw_d;
    logic [31:0] wb_addr_q, wb_addr_d;
    logic [3:0]  wb_rmask_q, wb_rmask_d;
    logic [3:0]  wb_wmask_q, wb_wmask_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic [31:0] wb_pc_q, wb_pc_d;

    logic        busy_c;
    logic        accept_c;
    logic [1:0]  off_c;
    logic [31:0] aligned_addr_c;
    logic [3:0]  mask_c;
    logic [31:0] wdata_c;
    logic [31:0] shifted_c;
    logic [31:0] load_c;

    assign busy_c         = (state_q != IDLE);
    assign bus.ex_rdy     = (state_q == IDLE) && !rst;
    assign accept_c       = bus.ex_valid && bus.ex_rdy && !bus.flush;
    assign off_c          = addr_q[1:0];
    assign aligned_addr_c = {addr_q[31:2], 2'b00};

    // Byte lanes and shifted store data for the latched access width.
    always_comb begin
        mask_c  = 4'b1111;
        wdata_c = rs2_q;
        case (funct3_q[1:0])
            2'b00: begin
                mask_c  = 4'(4'b0001 << off_c);
                wdata_c = 32'({24'b0, rs2_q[7:0]} << {off_c, 3'b000});
            end
            2'b01: begin
                mask_c  = 4'(4'b0011 << {off_c[1], 1'b0});
                wdata_c = 32'({16'b0, rs2_q[15:0]} << {off_c[1], 4'b0000});
            end
            default: ;
        endcase
    end

    // Extract and extend the addressed byte/halfword; funct3[2] selects zero-extension.
    always_comb begin
        shifted_c = bus.dmem_rdata;
        load_c    = bus.dmem_rdata;
        case (funct3_q[1:0])
            2'b00: begin
                shifted_c = bus.dmem_rdata >> {off_c, 3'b000};
                load_c    = {{24{shifted_c[7] & ~funct3_q[2]}}, shifted_c[7:0]};
            end
            2'b01: begin
                shifted_c = bus.dmem_rdata >> {off_c[1], 4'b0000};
                load_c    = {{16{shifted_c[15] & ~funct3_q[2]}}, shifted_c[15:0]};
            end
            default: ;
        endcase
    end

    // Request stays up through WAIT and DRAIN; reset withdraws it immediately.
    assign bus.dmem_address = aligned_addr_c;
    assign bus.dmem_read    = busy_c && read_q && !rst;
    assign bus.dmem_write   = busy_c && write_q && !rst;
    assign bus.dmem_wmask   = bus.dmem_write ? mask_c : 4'b0000;
    assign bus.dmem_wdata   = wdata_c;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rs2_d      = rs2_q;
        funct3_d   = funct3_q;
        read_d     = read_q;
        write_d    = write_q;
        cw_d       = cw_q;
        valid_d    = 1'b0;
        data_out_d = data_out_q;
        wb_alu_d   = wb_alu_q;
        wb_cw_d    = wb_cw_q;
        wb_addr_d  = wb_addr_q;
        wb_rmask_d = wb_rmask_q;
        wb_wmask_d = wb_wmask_q;
        wb_rdata_d = wb_rdata_q;
        wb_wdata_d = wb_wdata_q;
        wb_pc_d    = wb_pc_q;

        case (state_q)
            IDLE: begin
                if (accept_c && (bus.mem_read || bus.mem_write)) begin
                    addr_d   = bus.alu_out;
                    rs2_d    = bus.rs2_data;
                    funct3_d = bus.funct3;
                    read_d   = bus.mem_read;
                    write_d  = bus.mem_write;
                    cw_d     = bus.cw_in;
                    state_d  = WAIT;
                end else if (accept_c) begin
                    valid_d    = 1'b1;
                    data_out_d = 32'h0;
                    wb_alu_d   = bus.alu_out;
                    wb_cw_d    = bus.cw_in;
                    wb_addr_d  = 32'h0;
                    wb_rmask_d = 4'b0000;
                    wb_wmask_d = 4'b0000;
                    wb_rdata_d = 32'h0;
                    wb_wdata_d = 32'h0;
                    wb_pc_d    = bus.cw_in.rvfi.pc_rdata;
                end
            end
            WAIT: begin
                if (bus.dmem_resp) begin
                    state_d = IDLE;
                    if (!bus.flush) begin
                        valid_d    = 1'b1;
                        data_out_d = read_q ? load_c : 32'h0;
                        wb_alu_d   = addr_q;
                        wb_cw_d    = cw_q;
                        wb_addr_d  = aligned_addr_c;
                        wb_rmask_d = read_q ? mask_c : 4'b0000;
                        wb_wmask_d = write_q ? mask_c : 4'b0000;
                        wb_rdata_d = bus.dmem_rdata;
                        wb_wdata_d = write_q ? wdata_c : 32'h0;
                        wb_pc_d    = cw_q.rvfi.pc_rdata;
                    end
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.dmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rs2_q      <= '0;
            funct3_q   <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            cw_q       <= '0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
            wb_alu_q   <= '0;
            wb_cw_q    <= '0;
            wb_addr_q  <= '0;
            wb_rmask_q <= '0;
            wb_wmask_q <= '0;
            wb_rdata_q <= '0;
            wb_wdata_q <= '0;
            wb_pc_q    <= RESET_PC;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rs2_q      <= rs2_d;
            funct3_q   <= funct3_d;
            read_q     <= read_d;
            write_q    <= write_d;
            cw_q       <= cw_d;
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
            wb_alu_q   <= wb_alu_d;
            wb_cw_q    <= wb_cw_d;
            wb_addr_q  <= wb_addr_d;
            wb_rmask_q <= wb_rmask_d;
            wb_wmask_q <= wb_wmask_d;
            wb_rdata_q <= wb_rdata_d;
            wb_wdata_q <= wb_wdata_d;
            wb_pc_q    <= wb_pc_d;
        end
    end

    assign bus.mem_wb_valid = valid_q;
    assign bus.mem_data_out = data_out_q;
    assign bus.wb_alu_out   = wb_alu_q;
    assign bus.wb_cw        = wb_cw_q;
    assign bus.wb_mem_addr  = wb_addr_q;
    assign bus.wb_rmask     = wb_rmask_q;
    assign bus.wb_wmask     = wb_wmask_q;
    assign bus.wb_mem_rdata = wb_rdata_q;
    assign bus.wb_mem_wdata = wb_wdata_q;
    assign bus.wb_pc_rdata  = wb_pc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, non-memory op, loads, stores, flush and reset-in-flight.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mem_stage_if bus ();

    mem_stage #(.RESET_PC(32'h40000000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.ex_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.dmem_resp = 1'b0;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] rs2, input logic rd,
                         input logic wr, input logic [2:0] f3, input logic [31:0] pc);
        bus.ex_valid  = 1'b1;
        bus.alu_out   = addr;
        bus.rs2_data  = rs2;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.funct3    = f3;
        bus.cw_in     = '0;
        bus.cw_in.rvfi.pc_rdata = pc;
    endtask

    initial begin
        idle_inputs();
        bus.alu_out    = '0;
        bus.rs2_data   = '0;
        bus.funct3     = '0;
        bus.cw_in      = '0;
        bus.dmem_rdata = '0;

        tick();
        chk("ex_rdy_in_reset", 32'(bus.ex_rdy), 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("rst_valid", 32'(bus.mem_wb_valid), 32'd0);
        chk("rst_dmem_read", 32'(bus.dmem_read), 32'd0);
        chk("rst_dmem_write", 32'(bus.dmem_write), 32'd0);
        chk("rst_pc", bus.wb_pc_rdata, 32'h40000000);
        chk("rst_ex_rdy", 32'(bus.ex_rdy), 32'd1);

        // Non-memory op
        issue(32'h1234, 32'h0, 1'b0, 1'b0, 3'b010, 32'h100);
        tick();
        idle_inputs();
        chk("alu_valid", 32'(bus.mem_wb_valid), 32'd1);
        chk("alu_out", bus.wb_alu_out, 32'h1234);
        chk("alu_data", bus.mem_data_out, 32'h0);
        chk("alu_no_req", 32'({bus.dmem_read, bus.dmem_write}), 32'd0);
        chk("alu_pc", bus.wb_pc_rdata, 32'h100);
        tick();
        chk("alu_valid_one_cycle", 32'(bus.mem_wb_valid), 32'd0);

        // lb at offset 3, two request cycles
        issue(32'h80000003, 32'h0, 1'b1, 1'b0, 3'b000, 32'h104);
        tick();
        idle_inputs();
        bus.dmem_rdata = 32'h80FF7F01;
        chk("lb_read_c1", 32'(bus.dmem_read), 32'd1);
        chk("lb_addr", bus.dmem_address, 32'h80000000);
        chk("lb_ex_rdy_c1", 32'(bus.ex_rdy), 32'd0);
        chk("lb_valid_c1", 32'(bus.mem_wb_valid), 32'd0);
        chk("lb_wmask_zero", 32'(bus.dmem_wmask), 32'd0);
        tick();
        chk("lb_read_c2", 32'(bus.dmem_read), 32'd1);
        chk("lb_ex_rdy_c2", 32'(bus.ex_rdy), 32'd0);
        bus.dmem_resp = 1'b1;
        tick();
        bus.dmem_resp = 1'b0;
        chk("lb_valid", 32'(bus.mem_wb_valid), 32'd1);
        chk("lb_data", bus.mem_data_out, 32'hFFFFFF80);
        chk("lb_rmask", 32'(bus.wb_rmask), 32'h8);
        chk("lb_wb_wmask", 32'(bus.wb_wmask), 32'h0);
        chk("lb_wb_addr", bus.wb_mem_addr, 32'h80000000);
        chk("lb_wb_rdata", bus.wb_mem_rdata, 32'h80FF7F01);
        chk("lb_pc", bus.wb_pc_rdata, 32'h104);
        chk("lb_read_drop", 32'(bus.dmem_read), 32'd0);

        // lhu / lh at offset 2
        issue(32'h00000202, 32'h0, 1'b1, 1'b0, 3'b101, 32'h108);
        tick();
        idle_inputs();
        bus.dmem_rdata = 32'hBEEF0000;
        bus.dmem_resp  = 1'b1;
        tick();
        bus.dmem_resp = 1'b0;
        chk("lhu_data", bus.mem_data_out, 32'h0000BEEF);
        chk("lhu_rmask", 32'(bus.wb_rmask), 32'hC);
        issue(32'h00000202, 32'h0, 1'b1, 1'b0, 3'b001, 32'h10C);
        tick();
        idle_inputs();
        bus.dmem_resp = 1'b1;
        tick();
        bus.dmem_resp = 1'b0;
        chk("lh_valid", 32'(bus.mem_wb_valid), 32'd1);
        chk("lh_data", bus.mem_data_out, 32'hFFFFBEEF);

        // sb at 0x101
        issue(32'h00000101, 32'h000000AB, 1'b0, 1'b1, 3'b000, 32'h110);
        tick();
        idle_inputs();
        chk("sb_write", 32'(bus.dmem_write), 32'd1);
        chk("sb_read", 32'(bus.dmem_read), 32'd0);
        chk("sb_addr", bus.dmem_address, 32'h00000100);
        chk("sb_wmask", 32'(bus.dmem_wmask), 32'h2);
        chk("sb_wdata", bus.dmem_wdata, 32'h0000AB00);
        bus.dmem_resp = 1'b1;
        tick();
        bus.dmem_resp = 1'b0;
        chk("sb_valid", 32'(bus.mem_wb_valid), 32'd1);
        chk("sb_wb_wmask", 32'(bus.wb_wmask), 32'h2);
        chk("sb_wb_rmask", 32'(bus.wb_rmask), 32'h0);
        chk("sb_wb_wdata", bus.wb_mem_wdata, 32'h0000AB00);
        chk("sb_data", bus.mem_data_out, 32'h0);

        // sw flushed in WAIT, response three cycles later
        issue(32'h00000300, 32'hDEADBEEF, 1'b0, 1'b1, 3'b010, 32'h114);
        tick();
        idle_inputs();
        bus.flush = 1'b1;
        chk("swf_write_c1", 32'(bus.dmem_write), 32'd1);
        chk("swf_wmask", 32'(bus.dmem_wmask), 32'hF);
        chk("swf_wdata", bus.dmem_wdata, 32'hDEADBEEF);
        tick();
        bus.flush = 1'b0;
        chk("swf_write_c2", 32'(bus.dmem_write), 32'd1);
        chk("swf_valid_c2", 32'(bus.mem_wb_valid), 32'd0);
        chk("swf_ex_rdy_c2", 32'(bus.ex_rdy), 32'd0);
        tick();
        chk("swf_write_c3", 32'(bus.dmem_write), 32'd1);
        chk("swf_valid_c3", 32'(bus.mem_wb_valid), 32'd0);
        bus.dmem_resp = 1'b1;
        tick();
        bus.dmem_resp = 1'b0;
        chk("swf_valid_after", 32'(bus.mem_wb_valid), 32'd0);
        chk("swf_ex_rdy_after", 32'(bus.ex_rdy), 32'd1);
        chk("swf_write_after", 32'(bus.dmem_write), 32'd0);
        tick();
        chk("swf_valid_later", 32'(bus.mem_wb_valid), 32'd0);

        // sw with flush and response coincident
        issue(32'h00000304, 32'h12345678, 1'b0, 1'b1, 3'b010, 32'h118);
        tick();
        idle_inputs();
        bus.flush     = 1'b1;
        bus.dmem_resp = 1'b1;
        tick();
        idle_inputs();
        chk("swc_ex_rdy", 32'(bus.ex_rdy), 32'd1);
        chk("swc_valid", 32'(bus.mem_wb_valid), 32'd0);
        chk("swc_write", 32'(bus.dmem_write), 32'd0);
        tick();
        chk("swc_valid_later", 32'(bus.mem_wb_valid), 32'd0);

        // Flush in IDLE blocks acceptance
        issue(32'h00005555, 32'h0, 1'b0, 1'b0, 3'b010, 32'h11C);
        bus.flush = 1'b1;
        tick();
        idle_inputs();
        chk("idle_flush_valid", 32'(bus.mem_wb_valid), 32'd0);
        chk("idle_flush_alu_held", bus.wb_alu_out, 32'h00000101);

        // Stray response in IDLE is ignored
        bus.dmem_resp = 1'b1;
        tick();
        bus.dmem_resp = 1'b0;
        chk("stray_resp_valid", 32'(bus.mem_wb_valid), 32'd0);

        // Reset during WAIT
        issue(32'h00000400, 32'h0, 1'b1, 1'b0, 3'b010, 32'h120);
        tick();
        idle_inputs();
        chk("rstw_read_before", 32'(bus.dmem_read), 32'd1);
        rst = 1'b1;
        tick();
        chk("rstw_read", 32'(bus.dmem_read), 32'd0);
        chk("rstw_valid", 32'(bus.mem_wb_valid), 32'd0);
        chk("rstw_pc", bus.wb_pc_rdata, 32'h40000000);
        chk("rstw_alu", bus.wb_alu_out, 32'h0);
        rst = 1'b0;
        tick();
        chk("rstw_ex_rdy", 32'(bus.ex_rdy), 32'd1);
        chk("rstw_read_idle", 32'(bus.dmem_read), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
